// File: rtl/taylor_pipe_scheduler.sv
// Scheduler for the 4-stage recirculating Taylor datapath: decides inject vs. recirculate,
// mirrors per-slot occupancy/tags and buffers finished results in a small tagged FIFO.
module taylor_pipe_scheduler #(
   parameter int TAG_W     = 2,
   parameter int OUT_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_x,
   input  logic [2:0]        in_n,
   output logic [TAG_W-1:0]  in_tag,
   output logic [7:0]        dp_x,
   output logic [2:0]        dp_n,
   output logic              dp_sel,
   output logic              dp_init,
   input  logic              dp_ready,
   input  logic [31:0]       dp_y,
   input  logic              dp_overflow,
   input  logic              dp_valid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_y,
   output logic              out_overflow,
   output logic              out_ok,
   output logic [TAG_W-1:0]  out_tag,
   output logic [2:0]        inflight,
   output logic              busy
);
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int EW = 34 + TAG_W;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(OUT_DEPTH);

   typedef enum logic [0:0] {
      S_FLUSH = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       flush_cnt_q, flush_cnt_d;
   logic [3:0]       occ_q, occ_d;
   logic [TAG_W-1:0] tag_q [4];
   logic [TAG_W-1:0] tag_d [4];
   logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
   logic [EW-1:0]    mem_q [OUT_DEPTH];
   logic [EW-1:0]    mem_d [OUT_DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic [2:0]       inflight_q, inflight_d;

   logic             run_s, full_s, pop_s, complete_s, push_s, hold_s, accept_s;
   logic [EW-1:0]    head_s;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   // occ_q[3] is the ring head, aligned with the dp_* head inputs
   assign run_s      = (state_q == S_RUN) && !clear;
   assign full_s     = (cnt_q == FULL_CNT);
   assign out_valid  = (cnt_q != (PW+1)'(1'b0));
   assign pop_s      = out_valid && out_ready;
   assign complete_s = run_s && occ_q[3] && dp_ready;
   assign push_s     = complete_s && (!full_s || pop_s);
   assign hold_s     = run_s && occ_q[3] && !push_s;
   assign in_ready   = run_s && !hold_s;
   assign accept_s   = in_ready && in_valid;

   assign in_tag   = tag_cnt_q;
   assign dp_x     = in_x;
   assign dp_n     = in_n;
   assign dp_sel   = hold_s;
   assign dp_init  = (state_q == S_FLUSH);
   assign inflight = inflight_q;
   assign busy     = (inflight_q != 3'd0) || out_valid || (state_q != S_RUN);

   // Empty FIFO presents zeros rather than stale storage
   assign head_s       = out_valid ? mem_q[rd_ptr_q] : {EW{1'b0}};
   assign out_y        = head_s[EW-1 -: 32];
   assign out_overflow = head_s[TAG_W+1];
   assign out_ok       = head_s[TAG_W];
   assign out_tag      = head_s[TAG_W-1:0];

   // Next-state logic for the controller, slot mirror and result FIFO
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      occ_d       = occ_q;
      tag_d       = tag_q;
      tag_cnt_d   = tag_cnt_q;
      mem_d       = mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      if (clear) begin
         state_d     = S_FLUSH;
         flush_cnt_d = 2'd0;
         occ_d       = 4'd0;
         rd_ptr_d    = {PW{1'b0}};
         wr_ptr_d    = {PW{1'b0}};
         cnt_d       = {(PW+1){1'b0}};
      end else begin
         case (state_q)
            S_FLUSH: begin
               occ_d = 4'd0;
               if (flush_cnt_q == 2'd3) begin
                  state_d     = S_RUN;
                  flush_cnt_d = 2'd0;
               end else begin
                  flush_cnt_d = flush_cnt_q + 2'd1;
               end
            end
            S_RUN: begin
               occ_d    = {occ_q[2:0], hold_s | accept_s};
               tag_d[3] = tag_q[2];
               tag_d[2] = tag_q[1];
               tag_d[1] = tag_q[0];
               if (hold_s) begin
                  tag_d[0] = tag_q[3];
               end else if (accept_s) begin
                  tag_d[0]  = tag_cnt_q;
                  tag_cnt_d = tag_cnt_q + TAG_W'(1'b1);
               end else begin
                  tag_d[0] = tag_q[0];
               end
            end
            default: begin
               state_d     = S_FLUSH;
               flush_cnt_d = 2'd0;
               occ_d       = 4'd0;
            end
         endcase
         if (push_s) begin
            mem_d[wr_ptr_q] = {dp_y, dp_overflow, dp_valid, tag_q[3]};
            wr_ptr_d        = wr_ptr_q + PW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         cnt_d = cnt_q + (PW+1)'(push_s) - (PW+1)'(pop_s);
      end
      inflight_d = popcount4(occ_d);
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_FLUSH;
         flush_cnt_q <= 2'd0;
         occ_q       <= 4'd0;
         tag_cnt_q   <= {TAG_W{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         wr_ptr_q    <= {PW{1'b0}};
         cnt_q       <= {(PW+1){1'b0}};
         inflight_q  <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            tag_q[i] <= {TAG_W{1'b0}};
         end
         for (int i = 0; i < OUT_DEPTH; i++) begin
            mem_q[i] <= {EW{1'b0}};
         end
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         occ_q       <= occ_d;
         tag_cnt_q   <= tag_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         inflight_q  <= inflight_d;
         tag_q       <= tag_d;
         mem_q       <= mem_d;
      end
   end

endmodule

// File: tb/tb_taylor_pipe_scheduler.sv
// Directed bench for taylor_pipe_scheduler with a behavioural 4-slot recirculating datapath
// (y = x * passes, done after n+1 passes or once y exceeds 1000).
module tb_taylor_pipe_scheduler;
   logic        clk;
   logic        rst, clear, in_valid, in_ready, dp_sel, dp_init, dp_ready;
   logic [7:0]  in_x, dp_x;
   logic [2:0]  in_n, dp_n, inflight;
   logic [1:0]  in_tag, out_tag;
   logic [31:0] dp_y, out_y;
   logic        dp_overflow, dp_valid, out_valid, out_ready, out_overflow, out_ok, busy;

   int n_chk = 0;
   int n_fail = 0;
   int lat, got, stale;
   logic [1:0]  rt [8];
   logic [31:0] ry [8];

   taylor_pipe_scheduler #(.TAG_W(2), .OUT_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_n(in_n), .in_tag(in_tag),
      .dp_x(dp_x), .dp_n(dp_n), .dp_sel(dp_sel), .dp_init(dp_init),
      .dp_ready(dp_ready), .dp_y(dp_y), .dp_overflow(dp_overflow), .dp_valid(dp_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_overflow(out_overflow), .out_ok(out_ok), .out_tag(out_tag),
      .inflight(inflight), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural datapath ring; index 3 is the head
   logic       m_vld [4];
   logic [7:0] m_x [4];
   logic [2:0] m_n [4];
   logic [3:0] m_k [4];
   logic [31:0] m_y [4];
   logic       m_ovf [4];
   logic       head_done;
   logic [31:0] y_next;

   assign head_done   = m_vld[3] && ((m_k[3] > {1'b0, m_n[3]}) || m_ovf[3]);
   assign y_next      = m_y[3] + {24'd0, m_x[3]};
   assign dp_ready    = !m_vld[3] || head_done;
   assign dp_y        = m_y[3];
   assign dp_overflow = m_ovf[3];
   assign dp_valid    = m_vld[3];

   always @(posedge clk or negedge rst) begin
      if (!rst || dp_init) begin
         for (int i = 0; i < 4; i++) begin
            m_vld[i] <= 1'b0; m_x[i] <= 8'd0; m_n[i] <= 3'd0;
            m_k[i] <= 4'd0; m_y[i] <= 32'd0; m_ovf[i] <= 1'b0;
         end
      end else begin
         for (int i = 1; i < 4; i++) begin
            m_vld[i] <= m_vld[i-1]; m_x[i] <= m_x[i-1]; m_n[i] <= m_n[i-1];
            m_k[i] <= m_k[i-1]; m_y[i] <= m_y[i-1]; m_ovf[i] <= m_ovf[i-1];
         end
         if (dp_sel) begin
            m_vld[0] <= m_vld[3]; m_x[0] <= m_x[3]; m_n[0] <= m_n[3];
            if (head_done) begin
               m_k[0] <= m_k[3]; m_y[0] <= m_y[3]; m_ovf[0] <= m_ovf[3];
            end else begin
               m_k[0] <= m_k[3] + 4'd1; m_y[0] <= y_next; m_ovf[0] <= (y_next > 32'd1000);
            end
         end else begin
            m_vld[0] <= in_valid && in_ready; m_x[0] <= in_x; m_n[0] <= in_n;
            m_k[0] <= 4'd1; m_y[0] <= {24'd0, in_x}; m_ovf[0] <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] x, input logic [2:0] n, input logic [1:0] etag);
      in_valid = 1'b1; in_x = x; in_n = n;
      #1;
      chk("in_tag", {30'd0, in_tag}, {30'd0, etag});
      chk("in_ready_at_send", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic flush_check();
      for (int i = 0; i < 4; i++) begin
         chk("flush_dp_init", {31'd0, dp_init}, 32'd1);
         chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      chk("run_dp_init", {31'd0, dp_init}, 32'd0);
      chk("run_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic wait_out();
      lat = 0;
      while (!out_valid && lat < 64) begin
         tick();
         lat++;
      end
   endtask

   task automatic collect(input int nexp);
      got = 0;
      for (int c = 0; c < 80 && got < nexp; c++) begin
         if (out_valid && out_ready) begin
            rt[got] = out_tag; ry[got] = out_y; got++;
         end
         tick();
      end
      chk("collect_count", got, nexp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_x = 8'd0; in_n = 3'd0; out_ready = 1'b0;
      #2;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_dp_init", {31'd0, dp_init}, 32'd1);
      chk("rst_dp_sel", {31'd0, dp_sel}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_y", out_y, 32'd0);
      chk("rst_inflight", {29'd0, inflight}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      repeat (3) tick();
      rst = 1'b1;
      flush_check();
      chk("idle_inflight", {29'd0, inflight}, 32'd0);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Single operand: x=1, n=0 -> y=1 after exactly 4 cycles
      send(8'd1, 3'd0, 2'd0);
      chk("single_inflight", {29'd0, inflight}, 32'd1);
      wait_out();
      chk("single_latency", lat, 32'd4);
      chk("single_y", out_y, 32'd1);
      chk("single_tag", {30'd0, out_tag}, 32'd0);
      chk("single_ok", {31'd0, out_ok}, 32'd1);
      chk("single_ovf", {31'd0, out_overflow}, 32'd0);
      chk("single_inflight_done", {29'd0, inflight}, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("single_popped", {31'd0, out_valid}, 32'd0);
      chk("single_busy", {31'd0, busy}, 32'd0);

      // Back-to-back: completion order B, D, C, A
      send(8'd3, 3'd2, 2'd1);
      send(8'd5, 3'd0, 2'd2);
      send(8'd7, 3'd1, 2'd3);
      send(8'd2, 3'd0, 2'd0);
      chk("b2b_inflight", {29'd0, inflight}, 32'd4);
      chk("b2b_in_ready_full", {31'd0, in_ready}, 32'd0);
      chk("b2b_sel_hold", {31'd0, dp_sel}, 32'd1);
      tick();
      chk("b2b_in_ready_free", {31'd0, in_ready}, 32'd1);
      chk("b2b_sel_push", {31'd0, dp_sel}, 32'd0);
      collect(4);
      chk("b2b_tag0", {30'd0, rt[0]}, 32'd2); chk("b2b_y0", ry[0], 32'd5);
      chk("b2b_tag1", {30'd0, rt[1]}, 32'd0); chk("b2b_y1", ry[1], 32'd2);
      chk("b2b_tag2", {30'd0, rt[2]}, 32'd3); chk("b2b_y2", ry[2], 32'd14);
      chk("b2b_tag3", {30'd0, rt[3]}, 32'd1); chk("b2b_y3", ry[3], 32'd9);
      chk("b2b_inflight_end", {29'd0, inflight}, 32'd0);

      // Backpressure: FIFO of 2 fills, third result recirculates
      out_ready = 1'b0;
      send(8'd10, 3'd0, 2'd1);
      send(8'd11, 3'd0, 2'd2);
      send(8'd12, 3'd0, 2'd3);
      repeat (3) tick();
      chk("bp_sel_hold1", {31'd0, dp_sel}, 32'd1);
      chk("bp_in_ready1", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_inflight", {29'd0, inflight}, 32'd1);
      repeat (4) tick();
      chk("bp_sel_hold2", {31'd0, dp_sel}, 32'd1);
      chk("bp_in_ready2", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_sel_release", {31'd0, dp_sel}, 32'd0);
      chk("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
      collect(3);
      chk("bp_tag0", {30'd0, rt[0]}, 32'd1); chk("bp_y0", ry[0], 32'd10);
      chk("bp_tag1", {30'd0, rt[1]}, 32'd2); chk("bp_y1", ry[1], 32'd11);
      chk("bp_tag2", {30'd0, rt[2]}, 32'd3); chk("bp_y2", ry[2], 32'd12);
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // Overflow: x=200, n=7 overflows on pass 6 (y=1200), freeing the slot 8 cycles early
      send(8'd200, 3'd7, 2'd0);
      wait_out();
      chk("ovf_latency", lat, 32'd24);
      chk("ovf_flag", {31'd0, out_overflow}, 32'd1);
      chk("ovf_y", out_y, 32'd1200);
      chk("ovf_ok", {31'd0, out_ok}, 32'd1);
      chk("ovf_tag", {30'd0, out_tag}, 32'd0);
      tick();
      chk("ovf_popped", {31'd0, out_valid}, 32'd0);

      // Clear with three operands in flight and one result waiting
      out_ready = 1'b0;
      send(8'd9, 3'd0, 2'd1);
      send(8'd1, 3'd7, 2'd2);
      send(8'd2, 3'd7, 2'd3);
      send(8'd3, 3'd7, 2'd0);
      tick();
      chk("clr_inflight_before", {29'd0, inflight}, 32'd3);
      chk("clr_out_valid_before", {31'd0, out_valid}, 32'd1);
      clear = 1'b1;
      #1;
      chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      clear = 1'b0;
      chk("clr_inflight", {29'd0, inflight}, 32'd0);
      chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
      chk("clr_tag_kept", {30'd0, in_tag}, 32'd1);
      flush_check();
      out_ready = 1'b1;
      stale = 0;
      repeat (40) begin
         if (out_valid) stale++;
         tick();
      end
      chk("clr_no_stale", stale, 32'd0);

      // Asynchronous reset mid-run
      out_ready = 1'b0;
      send(8'd4, 3'd0, 2'd1);
      repeat (4) tick();
      chk("mrst_out_valid_before", {31'd0, out_valid}, 32'd1);
      send(8'd5, 3'd7, 2'd2);
      chk("mrst_inflight_before", {29'd0, inflight}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mrst_dp_init", {31'd0, dp_init}, 32'd1);
      chk("mrst_dp_sel", {31'd0, dp_sel}, 32'd0);
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_out_y", out_y, 32'd0);
      chk("mrst_out_tag", {30'd0, out_tag}, 32'd0);
      chk("mrst_out_ok", {31'd0, out_ok}, 32'd0);
      chk("mrst_inflight", {29'd0, inflight}, 32'd0);
      chk("mrst_busy", {31'd0, busy}, 32'd1);
      chk("mrst_in_tag", {30'd0, in_tag}, 32'd0);
      tick();
      rst = 1'b1;
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
